// File: rtl/asu_riscv_multdiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | asu_riscv_multdiv_pkg: shared types/helpers for the M-ext unit     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package asu_riscv_multdiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state;

  function automatic logic is_div(input md_op op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_rem(input md_op op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  function automatic logic is_signed_a(input md_op op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic is_signed_b(input md_op op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage
`default_nettype wire

// File: rtl/asu_riscv_mul_chunk.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | asu_riscv_mul_chunk: |a| x one op_b slice plus accumulator top half|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module asu_riscv_mul_chunk #(
  parameter int XLEN      = 32,
  parameter int MUL_CHUNK = 8
) (
  input  logic [XLEN-1:0]           mag_a,
  input  logic [MUL_CHUNK-1:0]      b_slice,
  input  logic [XLEN-1:0]           acc_hi,
  output logic [XLEN+MUL_CHUNK-1:0] sum
);
  localparam int c_PP_W = XLEN + MUL_CHUNK;

  logic [c_PP_W-1:0] w_pp;

  // Sum is bounded by (2^XLEN-1)*2^MUL_CHUNK, so it never overflows c_PP_W.
  assign w_pp = c_PP_W'(mag_a) * c_PP_W'(b_slice);
  assign sum  = w_pp + c_PP_W'(acc_hi);

endmodule
`default_nettype wire

// File: rtl/asu_riscv_multdiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | asu_riscv_multdiv_seq: iterative RV32M/RV64M multiply-divide unit  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module asu_riscv_multdiv_seq
  import asu_riscv_multdiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            kill_i,
  input  logic [2:0]      operator_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);
  localparam int              c_MUL_STEPS = XLEN / MUL_CHUNK;
  localparam int              c_CNT_W     = $clog2(XLEN);
  localparam logic [XLEN-1:0] c_INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  if ((XLEN != 32 && XLEN != 64) || (XLEN % MUL_CHUNK != 0) ||
      !(MUL_CHUNK == 1 || MUL_CHUNK == 2 || MUL_CHUNK == 4 ||
        MUL_CHUNK == 8 || MUL_CHUNK == 16)) begin : g_bad_param
    $error("asu_riscv_multdiv_seq: illegal XLEN/MUL_CHUNK combination");
  end

  md_state              r_state, w_state_next;
  md_op                 r_op, w_op;
  logic [XLEN-1:0]      r_a, r_b, r_quo, r_rem, r_result;
  logic [2*XLEN-1:0]    r_acc;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_neg, r_special;

  logic                      w_accept, w_sa, w_sb;
  logic                      w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0]           w_mag_a, w_mag_b, w_special_val;
  logic [XLEN+MUL_CHUNK-1:0] w_mul_sum;
  logic [2*XLEN-1:0]         w_acc_next, w_prod;
  logic [XLEN:0]             w_trial_in, w_trial;
  logic [XLEN-1:0]           w_rem_next, w_quo_fix, w_rem_fix, w_fix_result;

  assign w_op     = md_op'(operator_i);
  assign ready_o  = (r_state == IDLE);
  assign valid_o  = (r_state == DONE);
  assign result_o = r_result;
  assign w_accept = valid_i & ready_o & ~kill_i;

  assign w_sa    = is_signed_a(w_op) & op_a_i[XLEN-1];
  assign w_sb    = is_signed_b(w_op) & op_b_i[XLEN-1];
  assign w_mag_a = w_sa ? -op_a_i : op_a_i;
  assign w_mag_b = w_sb ? -op_b_i : op_b_i;

  // Divide-by-zero and INT_MIN/-1 are resolved at accept and skip CALC.
  assign w_div_zero    = is_div(w_op) && (op_b_i == '0);
  assign w_div_ovf     = is_div(w_op) && is_signed_b(w_op) &&
                         (op_a_i == c_INT_MIN) && (op_b_i == '1);
  assign w_special     = w_div_zero || w_div_ovf;
  assign w_special_val = w_div_zero ? (is_rem(w_op) ? op_a_i : '1)
                                    : (is_rem(w_op) ? '0 : op_a_i);

  asu_riscv_mul_chunk #(
    .XLEN      (XLEN),
    .MUL_CHUNK (MUL_CHUNK)
  ) u_mul_chunk (
    .mag_a   (r_a),
    .b_slice (r_b[MUL_CHUNK-1:0]),
    .acc_hi  (r_acc[2*XLEN-1:XLEN]),
    .sum     (w_mul_sum)
  );
  assign w_acc_next = {w_mul_sum, r_acc[XLEN-1:MUL_CHUNK]};

  // Restoring divide step: r_quo shifts the dividend out and quotient bits in.
  assign w_trial_in = {r_rem, r_quo[XLEN-1]};
  assign w_trial    = w_trial_in - {1'b0, r_b};
  assign w_rem_next = w_trial[XLEN] ? w_trial_in[XLEN-1:0] : w_trial[XLEN-1:0];

  assign w_prod    = r_neg ? -r_acc : r_acc;
  assign w_quo_fix = r_neg ? -r_quo : r_quo;
  assign w_rem_fix = r_neg ? -r_rem : r_rem;

  always_comb begin
    w_fix_result = '0;
    if (r_special) begin
      w_fix_result = r_quo;
    end else begin
      case (r_op)
        MD_MUL:                       w_fix_result = w_prod[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:              w_fix_result = w_quo_fix;
        default:                      w_fix_result = w_rem_fix;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_special ? FIX : CALC;
      CALC:    if (r_cnt == '0) w_state_next = FIX;
      FIX:     w_state_next = DONE;
      DONE:    if (ready_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (kill_i) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= MD_MUL;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_special <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_a       <= w_mag_a;
      r_b       <= w_mag_b;
      r_acc     <= '0;
      r_quo     <= w_special ? w_special_val : w_mag_a;
      r_rem     <= '0;
      r_neg     <= is_rem(w_op) ? w_sa : (w_sa ^ w_sb);
      r_special <= w_special;
      r_cnt     <= is_div(w_op) ? c_CNT_W'(XLEN - 1) : c_CNT_W'(c_MUL_STEPS - 1);
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt - 1'b1;
      if (is_div(r_op)) begin
        r_rem <= w_rem_next;
        r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
      end else begin
        r_acc <= w_acc_next;
        r_b   <= r_b >> MUL_CHUNK;
      end
    end else if (r_state == FIX) begin
      r_result <= w_fix_result;
    end
  end

endmodule
`default_nettype wire
